// File: rtl/fetch_controller_if.sv
// Fetch-side bus bundle: instruction-memory address/data plus the decode handshake.
// Latency: none (wires only).
// Backpressure: decode stalls the controller by holding instr_ready low.
interface fetch_controller_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_controller.sv
// Front-end fetch sequencer: owns the PC, fetches one word per cycle into a small buffer.
// Latency: start at edge N gives the first valid instruction in cycle N+2; redirect costs 2 cycles.
// Backpressure: instr_ready low fills the buffer to DEPTH, then fetch stalls and the PC holds.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      halt_req,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    fetch_controller_if.master        fif,
    output logic                      busy,
    output logic [15:0]               fetch_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [31:0]   buf_dat [DEPTH];
    logic [31:0]   buf_pc  [DEPTH];
    logic          push;
    logic          pop;
    logic [CW-1:0] wr_slot;
    logic [AW-1:0] wr_idx;

    // Redirect masks the handshake so a flushed head can never be consumed.
    assign fif.instr_valid = (count != '0) && !redirect_valid;
    assign pop             = fif.instr_valid && fif.instr_ready;
    assign fif.imem_addr   = pc;
    assign fif.instr       = buf_dat[0];
    assign fif.instr_pc    = buf_pc[0];
    assign busy            = (state == RUN);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        wr_slot   = count - CW'(pop);
        wr_idx    = wr_slot[AW-1:0];
        case (state)
            IDLE: if (start && !halt_req) state_nxt = RUN;
            RUN:  if (halt_req) state_nxt = HALT;
            HALT: if (start && !halt_req) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (state == RUN && !redirect_valid && (count != FULL || pop))
            push = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Shift-down buffer: slot 0 is always the head, so instr/instr_pc come straight
    // from a register and keep the last popped word when the buffer runs empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC & ~32'h3;
            count       <= '0;
            fetch_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_dat[i] <= '0;
                buf_pc[i]  <= '0;
            end
        end else if (redirect_valid) begin
            pc    <= redirect_pc & ~32'h3;
            count <= '0;
        end else begin
            if (pop && count > CW'(1)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    buf_dat[i] <= buf_dat[i+1];
                    buf_pc[i]  <= buf_pc[i+1];
                end
            end
            if (push) begin
                buf_dat[wr_idx] <= fif.imem_data;
                buf_pc[wr_idx]  <= pc;
                pc              <= pc + 32'd4;
                fetch_count     <= fetch_count + 16'd1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
